// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle between the operand source, the multiplier and the product consumer.
// The multiplier uses the slave view; the source/consumer side uses the master view.
interface shift_add_multiplier_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product
    );

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add 32x32->64 unsigned multiplier, one multiplier bit per clock,
// using a single 32-bit ripple-carry adder whose 33-bit sum feeds the accumulator.

module rippleadder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [32:0] o_sum
);
    logic [32:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_fa
            assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_sum[32] = w_carry[32];
endmodule

module shift_add_multiplier (
    input  logic                        clk,
    input  logic                        rst_n,
    shift_add_multiplier_if.slave       bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_mcand;
    logic [31:0] r_acc_hi;
    logic [31:0] r_mlr;
    logic [4:0]  r_cnt;

    logic [31:0] w_addend;
    logic [32:0] w_sum;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;

    assign w_addend = r_mlr[0] ? r_mcand : 32'h0;

    rippleadder u_adder (
        .i_a   (r_acc_hi),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    assign w_accept = w_in_ready & bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd31) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The low product half shifts into r_mlr as the multiplier bits are consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= 32'h0;
            r_acc_hi <= 32'h0;
            r_mlr    <= 32'h0;
            r_cnt    <= 5'd0;
        end else if (w_accept) begin
            r_mcand  <= bus.multiplicand;
            r_mlr    <= bus.multiplier;
            r_acc_hi <= 32'h0;
            r_cnt    <= 5'd0;
        end else if (r_state == S_RUN) begin
            r_acc_hi <= w_sum[32:1];
            r_mlr    <= {w_sum[0], r_mlr[31:1]};
            r_cnt    <= r_cnt + 5'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.product   = w_out_valid ? {r_acc_hi, r_mlr} : 64'h0;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: directed vectors with literal products plus a
// random soak checked cycle by cycle against a queue of A*B references.
module tb_shift_add_multiplier;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shift_add_multiplier_if bus ();

    shift_add_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    bit          busy    = 1'b0;
    bit          waiting = 1'b0;
    int          cyc     = 0;
    int          hs_cyc  = 0;
    bit          soak_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: an op is in flight from input handshake to output handshake,
    // its product is A*B, and out_valid appears 33 negedges after the handshake.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            busy    = 1'b0;
            waiting = 1'b0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!busy));
            if (bus.out_valid) begin
                if (waiting) begin
                    check("latency", 64'(cyc - hs_cyc), 64'd33);
                    waiting = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("product", bus.product, exp_q[0]);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    busy = 1'b0;
                end
            end else begin
                check("product_idle_zero", bus.product, 64'h0);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(64'(bus.multiplicand) * 64'(bus.multiplier));
                busy    = 1'b1;
                waiting = 1'b1;
                hs_cyc  = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.in_valid     = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never seen for %h x %h", a, b);
        end
        @(posedge clk);
        #1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL out_timeout: out_valid got 0 want 1");
        end
    endtask

    task automatic run_directed(input string name, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] req);
        bit ok;
        send(a, b);
        wait_out(ok);
        if (ok) check(name, bus.product, req);
        $display("op %s: %h x %h -> %h", name, a, b, bus.product);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        logic [31:0] a;
        logic [31:0] b;

        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.multiplicand = 32'h0;
        bus.multiplier   = 32'h0;

        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product",   bus.product,        64'h0);
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_directed("mul3x5",   32'd3,          32'd5,          64'h0000_0000_0000_000F);
        run_directed("mulmax",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
        run_directed("mulzero",  32'h0,          32'h1234_5678,  64'h0);
        run_directed("mulmsb",   32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000);

        // Backpressure: product held while the consumer stalls; new requests ignored.
        bus.out_ready = 1'b0;
        send(32'h1234, 32'h10);
        wait_out(ok);
        if (ok) check("bp_product", bus.product, 64'h12340);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid     = 1'b1;
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
            @(negedge clk);
            check("bp_valid_hold",   64'(bus.out_valid), 64'd1);
            check("bp_product_hold", bus.product,        64'h12340);
            check("bp_in_ready",     64'(bus.in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_after", 64'(bus.in_ready), 64'd1);
        $display("op backpressure: 1234 x 10 held 10 cycles");

        // Abort mid-operation with an asynchronous reset.
        @(posedge clk);
        #1;
        send(32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_product",   bus.product,        64'h0);
        $display("op abort: reset asserted mid-operation");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_directed("mul7x9", 32'd7, 32'd9, 64'd63);

        // Random soak with random source gaps and consumer stalls.
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 7))
                        0:       a = 32'h0;
                        1:       a = 32'hFFFF_FFFF;
                        default: a = $urandom;
                    endcase
                    case ($urandom_range(0, 7))
                        0:       b = 32'hFFFF_FFFF;
                        1:       b = 32'd1;
                        default: b = $urandom;
                    endcase
                    send(a, b);
                    if (k % 100 == 0) $display("soak op %0d: %h x %h", k, a, b);
                end
                soak_done = 1'b1;
            end
            begin
                while (!soak_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_busy",  64'(busy),         64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
